lift_motion_ctrl: RTL
=====================

LIFT_MOTION_CTRL -- requirements
Module: lift_motion_ctrl

Interface
REQ-001 SHALL have parameter N_FLOORS, default 7: number of floors, numbered 1..N_FLOORS, legal range 2..15.
REQ-002 SHALL have parameter FLOOR_W, default 4: floor bus width, holding N_FLOORS.
REQ-003 SHALL have parameter CLK_PER_MOVE, default 1000000000: cycles move stays high per one-floor travel, legal range >=1.
REQ-004 SHALL have parameter CLK_PER_HOLD, default 10000000: cycles of post-arrival/door dwell, legal range >=1.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-007 SHALL have port door_open, input, 1: door not closed.
REQ-008 SHALL have port estop, input, 1: emergency stop, level.
REQ-009 SHALL have port cur_floor, input, FLOOR_W: floor the car is at.
REQ-010 SHALL have port dir, input, 2: requested direction; STOP=00, DOWN=01, UP=10, UPDOWN=11.
REQ-011 SHALL have port next_floor, output, FLOOR_W: target floor while moving, else current floor.
REQ-012 SHALL have port move, output, 1: car travelling.
REQ-013 SHALL have port arrive, output, 1: one-cycle pulse on travel completion.
REQ-014 SHALL have port halted, output, 1: high while in HALT.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on an illegal request.

Function
REQ-016 SHALL be a registered FSM with states IDLE, MOVE, HOLD, HALT; all outputs registered.
REQ-017 SHALL use a 32-bit down-counter for the MOVE and HOLD durations.
REQ-018 IDLE with door_open=1 SHALL go to HOLD and load next_floor<=cur_floor, move=0.
REQ-019 IDLE with door_open=0 and dir=STOP SHALL stay in IDLE and load next_floor<=cur_floor.
REQ-020 IDLE with door_open=0, dir=UP, cur_floor<N_FLOORS SHALL go to MOVE with next_floor<=cur_floor+1 and move=1.
REQ-021 IDLE with door_open=0, dir=DOWN, cur_floor>1 SHALL go to MOVE with next_floor<=cur_floor-1 and move=1.
REQ-022 IDLE requests UP at N_FLOORS, DOWN at 1, UPDOWN, or cur_floor outside 1..N_FLOORS SHALL pulse err for one cycle, stay in IDLE, and leave next_floor and move unchanged.
REQ-023 move SHALL be high for exactly CLK_PER_MOVE cycles, starting the cycle after the IDLE decision.
REQ-024 In the cycle move falls, arrive SHALL be 1, state SHALL go to HOLD, and next_floor SHALL keep the target.
REQ-025 HOLD SHALL last exactly CLK_PER_HOLD cycles, then go to IDLE.
REQ-026 IDLE SHALL last at least one cycle before a new decision; ignoring door and estop, one floor step takes CLK_PER_MOVE+CLK_PER_HOLD+1 cycles.
REQ-027 dir and cur_floor SHALL be ignored outside IDLE.
REQ-028 door_open=1 during MOVE SHALL pulse err once, on the rising edge of door_open, and SHALL NOT stop travel.
REQ-029 estop=1 in any state SHALL go to HALT on the next edge with move=0, halted=1, counter cleared, and next_floor held.
REQ-030 estop overrides all simultaneous events; estop in the final MOVE cycle SHALL suppress arrive.
REQ-031 Leaving HALT (estop=0) SHALL go to HOLD with next_floor<=cur_floor, forcing a full dwell before any new move.
REQ-032 Floor arithmetic SHALL be FLOOR_W wide with no wrap, because of the REQ-020/021 guards.

Reset
REQ-033 Reset SHALL win over estop and all other inputs.
REQ-034 Reset values SHALL be: state IDLE, next_floor=1, move=0, arrive=0, halted=0, err=0, counter=0.
REQ-035 Reset mid-MOVE SHALL drop move in the next cycle with no arrive pulse.

Structure
REQ-036 Package lift_pkg SHALL hold the direction encodings, the FSM state enum, and the floor constant F_FST=1.
REQ-037 SHALL instantiate one sub-module lift_timer: a 32-bit loadable down-counter with load, value, clear, and a done output.

Verification
REQ-038 Use N_FLOORS=7, CLK_PER_MOVE=4, CLK_PER_HOLD=2 for all scenarios.
REQ-039 Reset, then cur_floor=3, dir=UP, door_open=0 -> next_floor=4, move high for 4 cycles, arrive pulses once, 2 HOLD cycles, then IDLE.
REQ-040 cur_floor=7, dir=UP -> err pulses once, move stays 0, next_floor unchanged; same for cur_floor=1, dir=DOWN and for dir=UPDOWN.
REQ-041 door_open=1 in IDLE with cur_floor=5 -> next_floor=5, HOLD repeats while the door is open, no move.
REQ-042 estop asserted in the 4th MOVE cycle -> halted=1, no arrive, next_floor held; estop released -> 2-cycle HOLD, then a new decision.
REQ-043 Reset asserted during MOVE together with estop -> all outputs at reset values the next cycle, next_floor=1.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared encodings for the lift motion controller: requested direction,
// controller state and the lowest floor number.
package lift_pkg;

  typedef enum logic [1:0] {
    DIR_STOP   = 2'b00,
    DIR_DOWN   = 2'b01,
    DIR_UP     = 2'b10,
    DIR_UPDOWN = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_HOLD,
    ST_HALT
  } state_t;

  localparam int unsigned F_FST = 1;

  // True when floor f lies in 1..n_floors.
  function automatic logic floor_ok(input int unsigned f, input int unsigned n_floors);
    return (f >= F_FST) && (f <= n_floors);
  endfunction

endpackage

// File: rtl/lift_timer.sv
// 32-bit loadable down-counter that times the travel and dwell phases.
// It counts down to zero and then holds there; done is high while at zero.
module lift_timer
  import lift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        clear,
  output logic        done
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lift_motion_ctrl.sv
// One-floor-per-request lift motion controller: IDLE decides, MOVE travels
// for CLK_PER_MOVE cycles, HOLD dwells for CLK_PER_HOLD cycles, HALT on estop.
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned N_FLOORS     = 7,
  parameter int unsigned FLOOR_W      = 4,
  parameter int unsigned CLK_PER_MOVE = 1000000000,
  parameter int unsigned CLK_PER_HOLD = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_open,
  input  logic               estop,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic [1:0]         dir,
  output logic [FLOOR_W-1:0] next_floor,
  output logic               move,
  output logic               arrive,
  output logic               halted,
  output logic               err
);

  localparam logic [31:0]        MOVE_LD = 32'(CLK_PER_MOVE - 1);
  localparam logic [31:0]        HOLD_LD = 32'(CLK_PER_HOLD - 1);
  localparam logic [FLOOR_W-1:0] TOP_F   = FLOOR_W'(N_FLOORS);
  localparam logic [FLOOR_W-1:0] FST_F   = FLOOR_W'(F_FST);
  localparam logic [FLOOR_W-1:0] ONE_F   = FLOOR_W'(1);

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_d;
  logic               move_d, arrive_d, halted_d, err_d;
  logic               door_q;
  logic               t_load, t_clear, t_done;
  logic [31:0]        t_value;
  logic               cur_ok;

  lift_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .value (t_value),
    .clear (t_clear),
    .done  (t_done)
  );

  assign cur_ok = floor_ok(int'(cur_floor), N_FLOORS);

  // The timer is loaded with duration-1 on the entering edge, so the phase
  // ends on the edge where done is already high.
  always_comb begin
    state_d  = state_q;
    floor_d  = next_floor;
    move_d   = move;
    arrive_d = 1'b0;
    halted_d = 1'b0;
    err_d    = 1'b0;
    t_load   = 1'b0;
    t_value  = HOLD_LD;
    t_clear  = 1'b0;

    if (estop) begin
      state_d  = ST_HALT;
      move_d   = 1'b0;
      halted_d = 1'b1;
      t_clear  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (door_open) begin
            state_d = ST_HOLD;
            floor_d = cur_floor;
            move_d  = 1'b0;
            t_load  = 1'b1;
            t_value = HOLD_LD;
          end else if (!cur_ok) begin
            err_d = 1'b1;
          end else begin
            case (dir_t'(dir))
              DIR_STOP: begin
                floor_d = cur_floor;
              end
              DIR_UP: begin
                if (cur_floor < TOP_F) begin
                  state_d = ST_MOVE;
                  floor_d = cur_floor + ONE_F;
                  move_d  = 1'b1;
                  t_load  = 1'b1;
                  t_value = MOVE_LD;
                end else begin
                  err_d = 1'b1;
                end
              end
              DIR_DOWN: begin
                if (cur_floor > FST_F) begin
                  state_d = ST_MOVE;
                  floor_d = cur_floor - ONE_F;
                  move_d  = 1'b1;
                  t_load  = 1'b1;
                  t_value = MOVE_LD;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: begin
                err_d = 1'b1;
              end
            endcase
          end
        end

        ST_MOVE: begin
          // Opening the door in motion is flagged once but never stops travel.
          err_d = door_open && !door_q;
          if (t_done) begin
            state_d  = ST_HOLD;
            move_d   = 1'b0;
            arrive_d = 1'b1;
            t_load   = 1'b1;
            t_value  = HOLD_LD;
          end
        end

        ST_HOLD: begin
          if (t_done) begin
            state_d = ST_IDLE;
          end
        end

        ST_HALT: begin
          state_d = ST_HOLD;
          floor_d = cur_floor;
          move_d  = 1'b0;
          t_load  = 1'b1;
          t_value = HOLD_LD;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      next_floor <= FST_F;
      move       <= 1'b0;
      arrive     <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_floor <= floor_d;
      move       <= move_d;
      arrive     <= arrive_d;
      halted     <= halted_d;
      err        <= err_d;
      door_q     <= door_open;
    end
  end

endmodule
